// File: rtl/sample_addr_pkg.sv
// Shared types and default geometry for the sample addressing frame block.
package sample_addr_pkg;

    localparam int DEFAULT_NSAMPLES = 1170;
    localparam int DEFAULT_NLINES   = 512;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMED     = 2'd1,
        ACQ       = 2'd2,
        WAIT_TRIG = 2'd3
    } frame_state_t;

endpackage

// File: rtl/trig_edge_detect.sv
// Registers the sweep trigger and emits a one-cycle pulse on its rising edge.
module trig_edge_detect (
    input  logic clock,
    input  logic reset_n,
    input  logic sclr,
    input  logic trigger,
    output logic rise
);

    logic trigger_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            trigger_q <= 1'b0;
        end else if (sclr) begin
            trigger_q <= 1'b0;
        end else begin
            trigger_q <= trigger;
        end
    end

    assign rise = trigger & ~trigger_q;

endmodule

// File: rtl/sample_addressing_frame.sv
// Generates per-sample write addresses for a frame of triggered A-lines.
// Optional SAMPLE_ADDR_PINGPONG_EN adds a bank output that alternates per frame.
module sample_addressing_frame
    import sample_addr_pkg::*;
#(
    parameter int NSAMPLES = DEFAULT_NSAMPLES,
    parameter int ADDR_W   = 11,
    parameter int NLINES   = DEFAULT_NLINES,
    parameter int LINE_W   = 10
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              sclr,
    input  logic              arm,
    input  logic              continuous,
    input  logic              trigger,
    output logic [ADDR_W-1:0] addr,
    output logic              wr_en,
    output logic [LINE_W-1:0] line_idx,
    output logic              line_done,
    output logic              frame_done,
    output logic              busy,
    output logic              overrun
`ifdef SAMPLE_ADDR_PINGPONG_EN
    ,
    output logic              bank
`endif
);

    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(NSAMPLES - 1);
    localparam logic [ADDR_W-1:0] PENULT_ADDR = ADDR_W'(NSAMPLES - 2);
    localparam logic [LINE_W-1:0] LAST_LINE   = LINE_W'(NLINES - 1);

    frame_state_t      state_q, state_d;
    logic [ADDR_W-1:0] addr_d;
    logic [LINE_W-1:0] line_idx_d;
    logic              wr_en_d, line_done_d, frame_done_d, busy_d, overrun_d;
    logic              trig_rise;

    trig_edge_detect u_edge (
        .clock   (clock),
        .reset_n (reset_n),
        .sclr    (sclr),
        .trigger (trigger),
        .rise    (trig_rise)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            addr       <= '0;
            wr_en      <= 1'b0;
            line_idx   <= '0;
            line_done  <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else if (sclr) begin
            state_q    <= IDLE;
            addr       <= '0;
            wr_en      <= 1'b0;
            line_idx   <= '0;
            line_done  <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr       <= addr_d;
            wr_en      <= wr_en_d;
            line_idx   <= line_idx_d;
            line_done  <= line_done_d;
            frame_done <= frame_done_d;
            busy       <= busy_d;
            overrun    <= overrun_d;
        end
    end

    // Outputs are computed one cycle early so the strobes line up with the last address.
    always_comb begin
        state_d      = state_q;
        addr_d       = '0;
        wr_en_d      = 1'b0;
        line_done_d  = 1'b0;
        frame_done_d = 1'b0;
        line_idx_d   = line_idx;
        overrun_d    = overrun;
        case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d    = ARMED;
                    line_idx_d = '0;
                    overrun_d  = 1'b0;
                end
            end
            ARMED, WAIT_TRIG: begin
                if (trig_rise) begin
                    state_d = ACQ;
                    wr_en_d = 1'b1;
                end
            end
            ACQ: begin
                if (trig_rise) begin
                    overrun_d = 1'b1;
                end
                if (addr == LAST_ADDR) begin
                    if (line_idx == LAST_LINE) begin
                        line_idx_d = '0;
                        state_d    = continuous ? ARMED : IDLE;
                    end else begin
                        line_idx_d = line_idx + 1'b1;
                        state_d    = WAIT_TRIG;
                    end
                end else begin
                    addr_d       = addr + 1'b1;
                    wr_en_d      = 1'b1;
                    line_done_d  = (addr == PENULT_ADDR);
                    frame_done_d = (addr == PENULT_ADDR) && (line_idx == LAST_LINE);
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

`ifdef SAMPLE_ADDR_PINGPONG_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bank <= 1'b0;
        end else if (sclr) begin
            bank <= 1'b0;
        end else if (frame_done) begin
            bank <= ~bank;
        end
    end
`endif

endmodule

// File: tb/tb_sample_addressing_frame.sv
// Table-driven self-checking bench for sample_addressing_frame (NSAMPLES=8, NLINES=3).
module tb_sample_addressing_frame;

    localparam int NS = 8;
    localparam int NL = 3;
    localparam int AW = 11;
    localparam int LW = 10;

    typedef struct {
        logic          arm;
        logic          cont;
        logic          trig;
        logic          sclr;
        logic [AW-1:0] e_addr;
        logic          e_wr;
        logic          e_ld;
        logic          e_fd;
        logic          e_busy;
        logic          e_ov;
        logic [LW-1:0] e_li;
        string         tag;
    } vec_t;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          sclr = 1'b0;
    logic          arm = 1'b0;
    logic          continuous = 1'b0;
    logic          trigger = 1'b0;
    logic [AW-1:0] addr;
    logic          wr_en;
    logic [LW-1:0] line_idx;
    logic          line_done;
    logic          frame_done;
    logic          busy;
    logic          overrun;
`ifdef SAMPLE_ADDR_PINGPONG_EN
    logic          bank;
`endif

    int   n_checks = 0;
    int   n_fails  = 0;
    vec_t vecs[$];

    logic [LW-1:0] cur_li   = '0;
    logic          cur_ov   = 1'b0;
    logic          cur_busy = 1'b0;
    logic          cur_cont = 1'b0;
    logic          exp_bank = 1'b0;
    logic          prev_fd  = 1'b0;

    sample_addressing_frame #(
        .NSAMPLES (NS),
        .ADDR_W   (AW),
        .NLINES   (NL),
        .LINE_W   (LW)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .sclr       (sclr),
        .arm        (arm),
        .continuous (continuous),
        .trigger    (trigger),
        .addr       (addr),
        .wr_en      (wr_en),
        .line_idx   (line_idx),
        .line_done  (line_done),
        .frame_done (frame_done),
        .busy       (busy),
        .overrun    (overrun)
`ifdef SAMPLE_ADDR_PINGPONG_EN
        ,
        .bank       (bank)
`endif
    );

    always #5 clock = ~clock;

    function automatic logic [25:0] exp_pack(input vec_t v);
        return {v.e_addr, v.e_wr, v.e_ld, v.e_fd, v.e_busy, v.e_ov, v.e_li};
    endfunction

    function automatic logic [25:0] act_pack();
        return {addr, wr_en, line_done, frame_done, busy, overrun, line_idx};
    endfunction

    task automatic checkOutput(input string name, input logic [25:0] act, input logic [25:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got %h, expected %h (addr,wr,ld,fd,busy,ov,li)", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clock);
        arm        = v.arm;
        continuous = v.cont;
        trigger    = v.trig;
        sclr       = v.sclr;
        @(posedge clock);
        #1;
    endtask

    task automatic step(input logic a, input logic c, input logic t, input logic s);
        vec_t v;
        v.arm = a; v.cont = c; v.trig = t; v.sclr = s;
        v.e_addr = '0; v.e_wr = 0; v.e_ld = 0; v.e_fd = 0; v.e_busy = 0; v.e_ov = 0; v.e_li = '0;
        v.tag = "step";
        applyStimulus(v);
    endtask

    task automatic add_row(input logic a, input logic c, input logic t, input logic s,
                           input logic [AW-1:0] ad, input logic wr, input logic ld, input logic fd,
                           input logic bz, input logic ov, input logic [LW-1:0] li, input string tag);
        vec_t v;
        v.arm = a; v.cont = c; v.trig = t; v.sclr = s;
        v.e_addr = ad; v.e_wr = wr; v.e_ld = ld; v.e_fd = fd;
        v.e_busy = bz; v.e_ov = ov; v.e_li = li; v.tag = tag;
        vecs.push_back(v);
    endtask

    task automatic add_idle(input int n, input logic t, input logic a, input string tag);
        for (int i = 0; i < n; i++)
            add_row(a, cur_cont, t, 1'b0, '0, 0, 0, 0, cur_busy, cur_ov, cur_li, tag);
    endtask

    task automatic add_arm(input string tag);
        cur_busy = 1'b1;
        cur_li   = '0;
        cur_ov   = 1'b0;
        add_row(1'b1, cur_cont, 1'b0, 1'b0, '0, 0, 0, 0, 1'b1, 1'b0, '0, tag);
    endtask

    task automatic add_sclr(input logic a, input logic t, input string tag);
        cur_busy = 1'b0;
        cur_li   = '0;
        cur_ov   = 1'b0;
        add_row(a, cur_cont, t, 1'b1, '0, 0, 0, 0, 0, 0, '0, tag);
    endtask

    // One triggered line: the edge row then one row per sample cycle up to stop_at.
    task automatic add_line(input int ovr_at, input logic hold, input int stop_at, input string tag);
        logic t, ld, fd, frame_end;
        add_row(1'b0, cur_cont, 1'b1, 1'b0, '0, 1, 0, 0, 1'b1, cur_ov, cur_li, tag);
        for (int a = 0; a < stop_at; a++) begin
            t = hold | (a == ovr_at);
            if (a == ovr_at) cur_ov = 1'b1;
            if (a < NS - 1) begin
                ld = (a + 1 == NS - 1);
                fd = ld && (cur_li == LW'(NL - 1));
                add_row(1'b0, cur_cont, t, 1'b0, AW'(a + 1), 1, ld, fd, 1'b1, cur_ov, cur_li, tag);
            end else begin
                frame_end = (cur_li == LW'(NL - 1));
                cur_li    = frame_end ? '0 : cur_li + 1'b1;
                cur_busy  = frame_end ? cur_cont : 1'b1;
                add_row(1'b0, cur_cont, t, 1'b0, '0, 0, 0, 0, cur_busy, cur_ov, cur_li, tag);
            end
        end
    endtask

    initial begin
        // Single-shot frame; first line with trigger held high for 20 cycles.
        add_arm("arm1");
        add_line(-1, 1'b1, NS, "held_line");
        add_idle(11, 1'b1, 1'b0, "held_wait");
        add_idle(1, 1'b0, 1'b0, "held_release");
        add_line(-1, 1'b0, NS, "line2");
        add_idle(3, 1'b0, 1'b0, "gap2");
        add_line(NS - 1, 1'b0, NS, "line3_last_ovr");
        add_idle(1, 1'b0, 1'b0, "idle_after");
        add_idle(1, 1'b1, 1'b0, "idle_trig");
        add_idle(1, 1'b0, 1'b0, "idle_low");

        // Overrun mid-line, arm ignored while busy, arm from IDLE clears overrun.
        add_arm("arm_clr_ov");
        add_line(3, 1'b0, NS, "ovr_line");
        add_idle(1, 1'b0, 1'b1, "arm_ignored");
        add_idle(2, 1'b0, 1'b0, "ovr_gap");
        add_line(-1, 1'b0, NS, "ovr_line2");
        add_idle(3, 1'b0, 1'b0, "ovr_gap2");
        add_line(-1, 1'b0, NS, "ovr_line3");
        add_idle(1, 1'b0, 1'b0, "ovr_idle");
        add_arm("arm_clears");

        // Synchronous clear at addr=5 wins over arm and a trigger edge.
        add_line(3, 1'b0, 5, "pre_sclr");
        add_sclr(1'b1, 1'b1, "sclr_mid");
        add_idle(2, 1'b0, 1'b0, "post_sclr");

        // Continuous mode, two frames back to back.
        cur_cont = 1'b1;
        add_idle(1, 1'b0, 1'b0, "cont_idle");
        add_arm("cont_arm");
        for (int f = 0; f < 2; f++) begin
            for (int l = 0; l < NL; l++) begin
                add_line(-1, 1'b0, NS, "cont_line");
                add_idle(3, 1'b0, 1'b0, "cont_gap");
            end
        end
        cur_cont = 1'b0;
        add_idle(1, 1'b0, 1'b0, "cont_off");
        add_sclr(1'b0, 1'b0, "final_sclr");

        #1;
        checkOutput("reset_state", act_pack(), '0);
`ifdef SAMPLE_ADDR_PINGPONG_EN
        checkOutput("reset_bank", {25'b0, bank}, 26'd0);
`endif
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            if (vecs[i].sclr) exp_bank = 1'b0;
            else if (prev_fd) exp_bank = ~exp_bank;
            prev_fd = vecs[i].e_fd;
            checkOutput($sformatf("%s[%0d]", vecs[i].tag, i), act_pack(), exp_pack(vecs[i]));
`ifdef SAMPLE_ADDR_PINGPONG_EN
            checkOutput($sformatf("bank_%s[%0d]", vecs[i].tag, i), {25'b0, bank}, {25'b0, exp_bank});
`endif
        end

        // Asynchronous reset in the middle of a line.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("pre_reset_addr", {15'b0, addr}, 26'd5);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_reset_now", act_pack(), '0);
        @(posedge clock);
        #1;
        checkOutput("async_reset_hold", act_pack(), '0);
        @(negedge clock);
        reset_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("after_reset_idle", act_pack(), '0);
`ifdef SAMPLE_ADDR_PINGPONG_EN
        checkOutput("after_reset_bank", {25'b0, bank}, 26'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
